// File: rtl/ctrl_pipe_reg_stages.sv
// Control-word pipeline for the MIPS datapath: DEPTH register stages carrying {ctrl, valid}.
// Provides load-use stall (hold stage 0, bubble stage 1), per-stage flush, EX branch resolution and a saturating bubble counter.
module ctrl_pipe_reg_stages #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned BRANCH_BIT = 0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_ctrl,
  input  logic                     in_valid,
  input  logic                     stall,
  input  logic [DEPTH-1:0]         flush,
  input  logic                     zero_flag,
  output logic [DEPTH*WIDTH-1:0]   out_ctrl,
  output logic [DEPTH-1:0]         out_valid,
  output logic                     out_branch_taken,
  output logic [15:0]              bubble_count
);

  localparam int unsigned CNT_W         = 16;
  localparam logic        STALL_BUBBLES = (DEPTH > 1);

  logic [DEPTH-1:0][WIDTH-1:0] r_ctrl;
  logic [DEPTH-1:0][WIDTH-1:0] w_ctrl_nxt;
  logic [DEPTH-1:0]            r_valid;
  logic [DEPTH-1:0]            w_valid_nxt;
  logic [CNT_W-1:0]            r_bubble_count;
  logic [CNT_W-1:0]            w_bubble_count_nxt;
  logic                        w_bubble_evt;

  // Next stage contents; priority flush > stall > advance
  always_comb begin
    w_ctrl_nxt  = r_ctrl;
    w_valid_nxt = r_valid;

    if (flush[0]) begin
      w_ctrl_nxt[0]  = '0;
      w_valid_nxt[0] = 1'b0;
    end else if (!stall) begin
      w_ctrl_nxt[0]  = in_ctrl;
      w_valid_nxt[0] = in_valid;
    end

    for (int k = 1; k < int'(DEPTH); k++) begin
      if (flush[k] || ((k == 1) && stall)) begin
        w_ctrl_nxt[k]  = '0;
        w_valid_nxt[k] = 1'b0;
      end else begin
        w_ctrl_nxt[k]  = r_ctrl[k-1];
        w_valid_nxt[k] = r_valid[k-1];
      end
    end
  end

  // One count per edge that creates any bubble; saturates instead of wrapping
  always_comb begin
    w_bubble_evt       = (stall && STALL_BUBBLES) || (|flush);
    w_bubble_count_nxt = r_bubble_count;
    if (w_bubble_evt && (r_bubble_count != {CNT_W{1'b1}})) begin
      w_bubble_count_nxt = r_bubble_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ctrl         <= '0;
      r_valid        <= '0;
      r_bubble_count <= '0;
    end else begin
      r_ctrl         <= w_ctrl_nxt;
      r_valid        <= w_valid_nxt;
      r_bubble_count <= w_bubble_count_nxt;
    end
  end

  assign out_ctrl         = r_ctrl;
  assign out_valid        = r_valid;
  assign bubble_count     = r_bubble_count;
  // Combinational from stage-0 registers: zero_flag arrives late in the EX cycle
  assign out_branch_taken = r_valid[0] & r_ctrl[0][BRANCH_BIT] & zero_flag;

endmodule

// File: tb/tb_ctrl_pipe_reg_stages.sv
// Directed bench for ctrl_pipe_reg_stages (WIDTH=8, DEPTH=3, BRANCH_BIT=0).
// Hand-computed expectations; out_ctrl is shown as {stage2, stage1, stage0}.
module tb_ctrl_pipe_reg_stages;

  logic        clock;
  logic        reset_n;
  logic [7:0]  in_ctrl;
  logic        in_valid;
  logic        stall;
  logic [2:0]  flush;
  logic        zero_flag;
  logic [23:0] out_ctrl;
  logic [2:0]  out_valid;
  logic        out_branch_taken;
  logic [15:0] bubble_count;

  int n_cmp  = 0;
  int n_fail = 0;

  ctrl_pipe_reg_stages #(.WIDTH(8), .DEPTH(3), .BRANCH_BIT(0)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .in_ctrl          (in_ctrl),
    .in_valid         (in_valid),
    .stall            (stall),
    .flush            (flush),
    .zero_flag        (zero_flag),
    .out_ctrl         (out_ctrl),
    .out_valid        (out_valid),
    .out_branch_taken (out_branch_taken),
    .bubble_count     (bubble_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_pipe(input string tag, input logic [23:0] e_ctrl,
                            input logic [2:0] e_valid, input logic [15:0] e_cnt);
    check({tag, "_ctrl"},  32'(out_ctrl),     32'(e_ctrl));
    check({tag, "_valid"}, 32'(out_valid),    32'(e_valid));
    check({tag, "_count"}, 32'(bubble_count), 32'(e_cnt));
  endtask

  task automatic pulse_reset();
    #2 reset_n = 1'b0;
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    in_ctrl   = 8'h00;
    in_valid  = 1'b0;
    stall     = 1'b0;
    flush     = 3'b000;
    zero_flag = 1'b0;
    #12 reset_n = 1'b1;
    step();

    // Load a word so the asynchronous reset has something to clear
    in_ctrl  = 8'hA5;
    in_valid = 1'b1;
    step();
    zero_flag = 1'b1;
    #1;
    check_pipe("preload", 24'h0000A5, 3'b001, 16'd0);
    check("preload_branch", 32'(out_branch_taken), 32'd1);

    // Mid-cycle reset clears everything without a clock edge
    pulse_reset();
    check_pipe("async_reset", 24'h000000, 3'b000, 16'd0);
    check("async_reset_branch", 32'(out_branch_taken), 32'd0);
    reset_n   = 1'b1;
    zero_flag = 1'b0;

    // Straight flow
    step();
    in_ctrl = 8'h11; step();
    in_ctrl = 8'h22; step();
    in_ctrl = 8'h33; step();
    check_pipe("flow", 24'h112233, 3'b111, 16'd0);

    // Stall: restart with stage0=22, stage1=11
    pulse_reset();
    reset_n = 1'b1;
    in_ctrl = 8'h11; step();
    in_ctrl = 8'h22; step();
    check_pipe("pre_stall", 24'h001122, 3'b011, 16'd0);
    stall   = 1'b1;
    in_ctrl = 8'hFF;
    step();
    check_pipe("stall1", 24'h110022, 3'b101, 16'd1);
    step();
    check_pipe("stall2", 24'h000022, 3'b001, 16'd2);
    stall   = 1'b0;
    in_ctrl = 8'h44;
    step();
    check_pipe("after_stall", 24'h002244, 3'b011, 16'd2);

    // Flush and stall on the same edge: one increment only
    flush   = 3'b001;
    stall   = 1'b1;
    in_ctrl = 8'hFF;
    step();
    check_pipe("flush_stall", 24'h220000, 3'b100, 16'd3);

    // Two flush bits, one of them on an existing bubble: still one increment
    flush   = 3'b110;
    stall   = 1'b0;
    in_ctrl = 8'h55;
    step();
    check_pipe("flush_multi", 24'h000055, 3'b001, 16'd4);
    flush = 3'b000;

    // Flush of the last stage only; earlier stages advance
    flush   = 3'b100;
    in_ctrl = 8'h66;
    step();
    check_pipe("flush_last", 24'h005566, 3'b011, 16'd5);
    flush = 3'b000;

    // Branch resolution from stage 0
    in_ctrl   = 8'h01;
    zero_flag = 1'b0;
    step();
    check("branch_zf0", 32'(out_branch_taken), 32'd0);
    zero_flag = 1'b1;
    #1;
    check("branch_zf1", 32'(out_branch_taken), 32'd1);
    in_valid = 1'b0;
    step();
    check("branch_invalid", 32'(out_branch_taken), 32'd0);
    in_valid = 1'b1;
    in_ctrl  = 8'h02;
    step();
    check("branch_bit_clear", 32'(out_branch_taken), 32'd0);
    zero_flag = 1'b0;
    check("branch_count", 32'(bubble_count), 32'd5);

    // Saturation: 70000 stall edges starting from count 5
    stall = 1'b1;
    repeat (65529) @(posedge clock);
    #1;
    check("sat_fffe", 32'(bubble_count), 32'h0000_FFFE);
    step();
    check("sat_ffff", 32'(bubble_count), 32'h0000_FFFF);
    repeat (70000 - 65530) @(posedge clock);
    #1;
    check("sat_hold", 32'(bubble_count), 32'h0000_FFFF);
    stall = 1'b0;
    step();
    step();
    check("sat_released", 32'(bubble_count), 32'h0000_FFFF);
    flush = 3'b111;
    step();
    check("sat_flush", 32'(bubble_count), 32'h0000_FFFF);
    flush = 3'b000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
